// File: rtl/g07_rr_bus_scheduler.sv
// g07_rr_bus_scheduler
// Round-robin owner selection for the g07 shared bus. A master keeps the bus
// until the addressed slave signals done, the decoder misses, or the
// watchdog expires. Abort causes are latched in err_code and counted in
// err_cnt.
//
// Every state update happens on the falling edge of sysClk. Breset is an
// active-low asynchronous reset.
//
// Handshake: a master holds need[i] high until it sees ack[i]. ack is one-hot
// and is held through GRANT and WAIT. dec_hit is sampled only in GRANT, and
// tdone is sampled only in WAIT. A need change during a transaction has no
// effect until the next IDLE scan.
//
// Ports
//   sysClk     bus clock (falling-edge active)
//   Breset     asynchronous active-low reset
//   need       per-master request
//   dec_hit    decoder hit for the granted address (GRANT)
//   tdone      OR of slave Tdone (WAIT)
//   ack        one-hot grant, zero when no owner
//   owner      index of granted master, 0 when no owner
//   busy       high in GRANT and WAIT
//   xfer_done  one-cycle pulse on success
//   err        one-cycle pulse on abort
//   err_code   last abort cause: 0 none, 1 decode miss, 2 timeout
//   err_cnt    saturating abort counter
//   state_dbg  current FSM state (0 IDLE, 1 GRANT, 2 WAIT, 3 RELEASE)
module g07_rr_bus_scheduler #(
    parameter int NM      = 7,
    parameter int TIMEOUT = 64
) (
    input  logic          sysClk,
    input  logic          Breset,
    input  logic [NM-1:0] need,
    input  logic          dec_hit,
    input  logic          tdone,
    output logic [NM-1:0] ack,
    output logic [2:0]    owner,
    output logic          busy,
    output logic          xfer_done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [7:0]    err_cnt,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [NM-1:0] ack_n;
    logic [2:0]    owner_n;
    logic          busy_n, xfer_done_n, err_n;
    logic [1:0]    err_code_n;
    logic [7:0]    err_cnt_n;
    logic [2:0]    rr_ptr, rr_ptr_n;
    logic [7:0]    wd_cnt, wd_cnt_n;

    // Round-robin scan. The request vector is rotated so that bit 0 is
    // rr_ptr. The lowest set bit then gives the offset of the winner from
    // the pointer. The offset is added back to rr_ptr, modulo NM.
    logic [NM-1:0] need_rot;
    logic          found;
    logic [3:0]    off;
    logic [3:0]    sel_sum;
    logic [2:0]    sel;

    always_comb begin
        need_rot = NM'({need, need} >> rr_ptr);
        found    = 1'b0;
        off      = '0;
        for (int k = NM - 1; k >= 0; k--) begin
            if (need_rot[k]) begin
                found = 1'b1;
                off   = 4'(k);
            end
        end
        sel_sum = {1'b0, rr_ptr} + off;
        if (sel_sum >= 4'(NM)) begin
            sel_sum = sel_sum - 4'(NM);
        end
        sel = sel_sum[2:0];
    end

    // The next transaction starts its scan just past the current owner.
    logic [2:0] rr_after_owner;
    assign rr_after_owner = (owner == 3'(NM - 1)) ? 3'd0 : owner + 3'd1;

    logic do_release;
    logic do_abort;
    logic [1:0] abort_code;

    always_comb begin
        state_n     = state;
        ack_n       = ack;
        owner_n     = owner;
        busy_n      = busy;
        xfer_done_n = 1'b0;
        err_n       = 1'b0;
        err_code_n  = err_code;
        err_cnt_n   = err_cnt;
        rr_ptr_n    = rr_ptr;
        wd_cnt_n    = wd_cnt;
        do_release  = 1'b0;
        do_abort    = 1'b0;
        abort_code  = 2'd0;

        case (state)
            S_IDLE: begin
                if (found) begin
                    state_n = S_GRANT;
                    ack_n   = {{(NM-1){1'b0}}, 1'b1} << sel;
                    owner_n = sel;
                    busy_n  = 1'b1;
                end
            end
            S_GRANT: begin
                if (dec_hit) begin
                    state_n  = S_WAIT;
                    wd_cnt_n = '0;
                end else begin
                    do_release = 1'b1;
                    do_abort   = 1'b1;
                    abort_code = 2'd1;
                end
            end
            S_WAIT: begin
                // tdone is tested first, so it wins when it arrives on the
                // last watchdog cycle.
                if (tdone) begin
                    do_release  = 1'b1;
                    xfer_done_n = 1'b1;
                end else if (wd_cnt == 8'(TIMEOUT - 1)) begin
                    do_release = 1'b1;
                    do_abort   = 1'b1;
                    abort_code = 2'd2;
                end else begin
                    wd_cnt_n = wd_cnt + 8'd1;
                end
            end
            S_RELEASE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                ack_n   = '0;
                owner_n = '0;
                busy_n  = 1'b0;
            end
        endcase

        if (do_release) begin
            state_n  = S_RELEASE;
            ack_n    = '0;
            owner_n  = '0;
            busy_n   = 1'b0;
            rr_ptr_n = rr_after_owner;
        end
        if (do_abort) begin
            err_n      = 1'b1;
            err_code_n = abort_code;
            err_cnt_n  = (err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
        end
    end

    always_ff @(negedge sysClk or negedge Breset) begin
        if (!Breset) begin
            state     <= S_IDLE;
            ack       <= '0;
            owner     <= '0;
            busy      <= 1'b0;
            xfer_done <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            err_cnt   <= 8'd0;
            rr_ptr    <= 3'd0;
            wd_cnt    <= 8'd0;
        end else begin
            state     <= state_n;
            ack       <= ack_n;
            owner     <= owner_n;
            busy      <= busy_n;
            xfer_done <= xfer_done_n;
            err       <= err_n;
            err_code  <= err_code_n;
            err_cnt   <= err_cnt_n;
            rr_ptr    <= rr_ptr_n;
            wd_cnt    <= wd_cnt_n;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_g07_rr_bus_scheduler.sv
// Bench for g07_rr_bus_scheduler (NM=7, TIMEOUT=4).
// A transaction-level model predicts every output on every cycle. It uses
// the arbitration rule, the ack duration derived from each transaction's
// slave plan, and the outcome of each transaction. Directed phases pin the
// model with hand-computed values.
module tb_g07_rr_bus_scheduler;

    localparam int NM = 7;
    localparam int TO = 4;

    logic          sysClk;
    logic          Breset;
    logic [NM-1:0] need;
    logic          dec_hit;
    logic          tdone;
    logic [NM-1:0] ack;
    logic [2:0]    owner;
    logic          busy;
    logic          xfer_done;
    logic          err;
    logic [1:0]    err_code;
    logic [7:0]    err_cnt;
    logic [1:0]    state_dbg;

    g07_rr_bus_scheduler #(.NM(NM), .TIMEOUT(TO)) dut (
        .sysClk    (sysClk),
        .Breset    (Breset),
        .need      (need),
        .dec_hit   (dec_hit),
        .tdone     (tdone),
        .ack       (ack),
        .owner     (owner),
        .busy      (busy),
        .xfer_done (xfer_done),
        .err       (err),
        .err_code  (err_code),
        .err_cnt   (err_cnt),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // ---------------- stimulus control ----------------
    bit            auto_mode = 1'b0;
    logic [NM-1:0] dir_need  = '0;
    bit            dir_hit   = 1'b1;
    int            dir_d     = 1;
    bit            plan_hit  = 1'b1;
    int            plan_d    = 1;
    int            rcnt      = 0;

    // Masters: in random mode each master drops need when it sees ack and
    // re-requests at random. Otherwise the directed vector is applied.
    always @(posedge sysClk) begin
        logic [NM-1:0] nv;
        logic [NM-1:0] bm;
        if (auto_mode) begin
            nv = need;
            for (int m = 0; m < NM; m++) begin
                bm = NM'(1) << m;
                if ((ack & bm) != 0) nv = nv & ~bm;
                else if ((nv & bm) == 0 && $urandom_range(0, 3) == 0) nv = nv | bm;
            end
            need = nv;
        end else begin
            need = dir_need;
        end
    end

    // Slave side: the plan (hit, tdone on WAIT cycle d) is fixed while ack
    // is high. dec_hit and tdone carry noise on cycles where the scheduler
    // does not sample them.
    always @(posedge sysClk) begin
        if (!Breset || ack == '0) begin
            rcnt    = 0;
            tdone   = 1'($urandom_range(0, 1));
            dec_hit = 1'($urandom_range(0, 1));
            if (auto_mode) begin
                plan_hit = ($urandom_range(0, 5) != 0);
                plan_d   = $urandom_range(1, TO + 2);
            end else begin
                plan_hit = dir_hit;
                plan_d   = dir_d;
            end
        end else begin
            rcnt++;
            if (rcnt == 1) begin
                dec_hit = plan_hit;
                tdone   = 1'($urandom_range(0, 1));
            end else begin
                dec_hit = 1'($urandom_range(0, 1));
                tdone   = (rcnt - 1 == plan_d);
            end
        end
    end

    // ---------------- reference model ----------------
    // The model works per transaction. The grant goes to the first
    // requester at or after the round-robin pointer. The ack then stays
    // high for a number of cycles that follows from the slave plan. One
    // release cycle carries the outcome pulse, and one idle cycle follows
    // before the next scan.
    logic [NM-1:0] m_ack;
    logic [2:0]    m_owner;
    logic          m_busy, m_xfer, m_err;
    logic [1:0]    m_code;
    logic [7:0]    m_cnt;
    int            m_rr, m_left, m_outcome;
    bit            m_rel;

    always @(negedge sysClk or negedge Breset) begin
        if (!Breset) begin
            m_ack <= '0; m_owner <= '0; m_busy <= 1'b0; m_xfer <= 1'b0; m_err <= 1'b0;
            m_code <= '0; m_cnt <= '0; m_rr <= 0; m_left <= 0; m_outcome <= 0; m_rel <= 1'b0;
        end else begin
            m_xfer <= 1'b0;
            m_err  <= 1'b0;
            if (m_left > 1) begin
                m_left <= m_left - 1;
            end else if (m_left == 1) begin
                m_left  <= 0;
                m_ack   <= '0;
                m_owner <= '0;
                m_busy  <= 1'b0;
                m_rel   <= 1'b1;
                m_rr    <= (int'(m_owner) + 1) % NM;
                if (m_outcome == 0) begin
                    m_xfer <= 1'b1;
                end else begin
                    m_err  <= 1'b1;
                    m_code <= 2'(m_outcome);
                    if (m_cnt != 8'd255) m_cnt <= m_cnt + 8'd1;
                end
            end else if (m_rel) begin
                m_rel <= 1'b0;
            end else if (need != '0) begin : pick
                int sel;
                int idx;
                sel = -1;
                for (int k = 0; k < NM; k++) begin
                    idx = (m_rr + k) % NM;
                    if (sel < 0 && ((need >> idx) & NM'(1)) != 0) sel = idx;
                end
                m_ack   <= NM'(1) << sel;
                m_owner <= 3'(sel);
                m_busy  <= 1'b1;
                if (!plan_hit) begin
                    m_left <= 1; m_outcome <= 1;
                end else if (plan_d <= TO) begin
                    m_left <= 1 + plan_d; m_outcome <= 0;
                end else begin
                    m_left <= 1 + TO; m_outcome <= 2;
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(posedge sysClk) begin
        if (Breset) begin
            check("ack", ack, m_ack);
            check("owner", owner, m_owner);
            check("busy", busy, m_busy);
            check("xfer_done", xfer_done, m_xfer);
            check("err", err, m_err);
            check("err_code", err_code, m_code);
            check("err_cnt", err_cnt, m_cnt);
            check("ack_onehot", 32'($countones(ack) <= 1), 1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge sysClk);
        #2 Breset = 1'b0;
        repeat (2) @(posedge sysClk);
        #2 Breset = 1'b1;
    endtask

    // Waits for the next grant, counts its ack-high cycles, and returns the
    // values seen in the release cycle. It returns on the release-cycle
    // posedge.
    task automatic measure(output int len, output logic [NM-1:0] a, output logic [2:0] o,
                           output logic x, output logic e, output logic [1:0] c,
                           output logic [7:0] n);
        int guard;
        guard = 0;
        len   = 0;
        while (ack == '0 && guard < 200) begin
            @(posedge sysClk);
            guard++;
        end
        check("grant_wait_bound", 32'(guard < 200), 1);
        a = ack;
        o = owner;
        while (ack != '0 && len < 300) begin
            len++;
            @(posedge sysClk);
        end
        x = xfer_done;
        e = err;
        c = err_code;
        n = err_cnt;
    endtask

    // ---------------- main sequence ----------------
    int            len, pulses, guard;
    logic [NM-1:0] a;
    logic [2:0]    o;
    logic          x, e;
    logic [1:0]    c;
    logic [7:0]    n;

    initial begin
        Breset = 1'b0;
        need = '0; dec_hit = 1'b0; tdone = 1'b0;
        repeat (2) @(posedge sysClk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_owner", owner, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {xfer_done, err}, 0);
        check("rst_err_code", err_code, 0);
        check("rst_err_cnt", err_cnt, 0);
        #1 Breset = 1'b1;

        // Single request: master 2, tdone on the 3rd WAIT cycle.
        dir_need = 7'b000_0100; dir_hit = 1'b1; dir_d = 3;
        measure(len, a, o, x, e, c, n);
        check("single_len", len, 4);
        check("single_ack", a, 7'b000_0100);
        check("single_owner", o, 2);
        check("single_xfer", x, 1);
        check("single_err", e, 0);
        // The pointer is now 3, so among 0, 3 and 6 master 3 wins.
        dir_need = 7'b100_1001;
        measure(len, a, o, x, e, c, n);
        check("rr_after_single", o, 3);
        dir_need = '0;

        // Fairness: all masters request continuously.
        do_reset();
        dir_need = 7'h7F; dir_hit = 1'b1; dir_d = 1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            measure(len, a, o, x, e, c, n);
            check("fair_owner", o, i % NM);
            check("fair_len", len, 2);
            if (x) pulses++;
        end
        check("fair_xfer_count", pulses, 8);
        dir_need = '0;

        // Timeout: master 5 first, then master 6.
        do_reset();
        dir_need = 7'b110_0000; dir_hit = 1'b1; dir_d = 200;
        measure(len, a, o, x, e, c, n);
        check("to_len", len, 5);
        check("to_ack", a, 7'b010_0000);
        check("to_err", e, 1);
        check("to_xfer", x, 0);
        check("to_code", c, 2);
        check("to_cnt", n, 1);
        measure(len, a, o, x, e, c, n);
        check("to_next_owner", o, 6);
        check("to_cnt2", n, 2);

        // Decode miss.
        dir_need = 7'b000_0001; dir_hit = 1'b0;
        measure(len, a, o, x, e, c, n);
        check("miss_len", len, 1);
        check("miss_err", e, 1);
        check("miss_code", c, 1);
        check("miss_cnt", n, 3);
        // tdone arrives on the last watchdog cycle.
        dir_hit = 1'b1; dir_d = TO;
        measure(len, a, o, x, e, c, n);
        check("simul_len", len, 5);
        check("simul_xfer", x, 1);
        check("simul_err", e, 0);
        check("simul_code_held", c, 1);
        dir_need = '0;

        // Randomised traffic, checked cycle by cycle against the model.
        auto_mode = 1'b1;
        repeat (4000) @(posedge sysClk);
        auto_mode = 1'b0;
        dir_need  = '0;
        repeat (12) @(posedge sysClk);

        // Reset in the middle of WAIT.
        do_reset();
        dir_need = 7'b000_1000; dir_hit = 1'b0;
        measure(len, a, o, x, e, c, n);
        check("pre_rst_cnt", n, 1);
        dir_hit = 1'b1; dir_d = 200;
        guard = 0;
        while (ack == '0 && guard < 50) begin
            @(posedge sysClk);
            guard++;
        end
        check("mid_grant_owner", owner, 3);
        repeat (2) @(posedge sysClk);
        #2 Breset = 1'b0;
        #1;
        check("mid_rst_ack", ack, 0);
        check("mid_rst_cnt", err_cnt, 0);
        check("mid_rst_pulses", {xfer_done, err}, 0);
        dir_need = 7'b000_1010;
        repeat (2) @(posedge sysClk);
        #2 Breset = 1'b1;
        measure(len, a, o, x, e, c, n);
        check("post_rst_owner", o, 1);
        dir_need = '0;

        // Saturation: 260 back-to-back decode misses.
        do_reset();
        dir_need = 7'h7F; dir_hit = 1'b0;
        pulses = 0; guard = 0;
        while (pulses < 260 && guard < 3000) begin
            @(posedge sysClk);
            guard++;
            if (err) pulses++;
        end
        dir_need = '0;
        check("sat_pulses", pulses, 260);
        check("sat_cnt", err_cnt, 255);
        repeat (6) @(posedge sysClk);
        check("sat_cnt_hold", err_cnt, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
